audio_voice: RTL and testbench
==============================

# audio_voice

Parametrised square-wave voice for the audio subsystem. It replaces the free-running single-note generator with a note-at-a-time engine. Notes are accepted over a valid/ready handshake as a frequency plus a duration in milliseconds. The half-period is computed with an on-block sequential divider, the tone plays for the requested time, and completion is signalled with a done pulse. The sequencer and sound-effect logic sit upstream; `o_pulse` drives the speaker pin or mixer.

## Interface
- `CLK_FREQ`, 12000000: input clock frequency in Hz.
- `FREQ_W`, 24: width of the note frequency in Hz.
- `DUR_W`, 16: width of the duration in ms.
- `DIV_W`, 24: width of the half-period and quotient; must satisfy 2^DIV_W > CLK_FREQ/2.
- `i_clk` input 1: sole clock, rising edge.
- `i_rst_n` input 1: reset, asynchronous and active-low.
- `i_valid` input 1: note request.
- `o_ready` output 1: block can accept a note.
- `i_freq` input FREQ_W: tone frequency in Hz; 0 means rest.
- `i_dur_ms` input DUR_W: note length in ms.
- `i_duty` input 8: high-time fraction, duty/256; present only with `AUDIO_VOICE_DUTY_EN`.
- `i_stop` input 1: abort the current note.
- `o_pulse` output 1: square-wave output.
- `o_busy` output 1: high when state is not IDLE.
- `o_done` output 1: one-cycle pulse when a note completes normally.

## Operation
- **States:** IDLE, CALC, PLAY.
- **Reset values:** state IDLE, `o_pulse`=0, `o_ready`=1, `o_busy`=0, `o_done`=0, all counters 0.
- **IDLE:**
  - Accept on `i_valid && o_ready`; capture freq, dur and duty.
  - dur=0: go nowhere; `o_done` pulses on the next cycle and the block stays IDLE.
  - freq=0 (rest): go directly to PLAY with the tone suppressed.
  - Otherwise go to CALC.
- **CALC:**
  - Restoring divide of CLK_FREQ by 2·freq, one quotient bit per cycle, DIV_W cycles, result H.
  - H=0 (freq > CLK_FREQ/2) is clamped to H=1.
  - Then go to PLAY.
- **PLAY, tone:**
  - Period counter p runs 0..2H−1 and wraps to 0.
  - `o_pulse` = (p < H), so the high phase comes first.
  - p restarts at 0 on PLAY entry.
- **PLAY, duration:**
  - Prescaler counts CLK_FREQ/1000 cycles per ms tick; the remaining-ms count decrements on each tick.
  - When the count reaches 0: `o_pulse`←0, `o_done` pulses, state→IDLE.
- **Rest:** `o_pulse` is held at 0 for the full duration; timing is otherwise identical to a tone.
- **Stop:** `i_stop` in CALC or PLAY forces IDLE on the next edge, `o_pulse`←0, and no `o_done`.
  - `i_stop` is ignored in IDLE.
  - `i_stop` wins over a simultaneous `i_valid`; that note is not accepted.
- **Reset mid-note:** the note is discarded immediately, all outputs go to their reset values, and no `o_done`.

## Timing
- `o_ready` is registered and high exactly when state=IDLE, including the cycle `o_done` is asserted. A new note can therefore be accepted in the cycle after done.
- Acceptance edge → CALC entry: 1 cycle. CALC lasts DIV_W cycles. First `o_pulse` high occurs at the PLAY entry edge.
- PLAY length is exactly dur·(CLK_FREQ/1000) cycles. `o_done` is asserted in the cycle after the last PLAY cycle.
- Rest notes skip CALC: PLAY entry is 1 cycle after acceptance.
- `o_pulse` is registered and glitch-free. Period = 2H cycles exactly; `i_freq` changes after capture have no effect.

## Configuration
- **`AUDIO_VOICE_DUTY_EN` defined:**
  - `i_duty` port exists.
  - High threshold T = (2H·duty)>>8 and `o_pulse` = (p < T).
  - duty=0 gives a silent tone with normal duration and `o_done`.
  - duty=128 is equivalent to 50%.
  - T is computed once at CALC exit; the one-cycle multiply is permitted there.
- **Undefined:** no `i_duty` port, fixed 50% duty, T=H.

## Test plan
- freq=1000, dur=2 → CALC lasts 24 cycles; `o_pulse` is high 6000 / low 6000 cycles for 2 periods; `o_done` occurs 24000 cycles after PLAY entry; `o_ready` returns to 1.
- freq=0, dur=1 → `o_pulse` is 0 for all 12000 PLAY cycles; `o_done` is asserted once; CALC is skipped.
- dur=0, freq=440 → `o_done` one cycle after acceptance; `o_busy` never asserts; `o_pulse` stays 0.
- freq=1000, dur=5, `i_stop` 3000 cycles into PLAY → `o_pulse` is 0 the next cycle, state IDLE, no `o_done`. Same-cycle `i_stop`+`i_valid` in IDLE → not accepted.
- freq=8000000 → H clamps to 1; `o_pulse` toggles every cycle. `i_rst_n` low mid-PLAY → outputs are at reset values asynchronously.
- With `AUDIO_VOICE_DUTY_EN`, freq=1000, duty=64 → 3000 cycles high, 9000 low per period. duty=0 → `o_pulse` stays 0 and `o_done` still arrives on time.

Source files
------------

// File: rtl/audio_voice_if.sv
// audio_voice_if: note request handshake into audio_voice.
// Carries i_duty only when AUDIO_VOICE_DUTY_EN is defined.
interface audio_voice_if #(
    parameter int FREQ_W = 24,
    parameter int DUR_W  = 16
);
    logic              i_valid;
    logic              o_ready;
    logic [FREQ_W-1:0] i_freq;
    logic [DUR_W-1:0]  i_dur_ms;
`ifdef AUDIO_VOICE_DUTY_EN
    logic [7:0]        i_duty;

    modport master (
        output i_valid, i_freq, i_dur_ms, i_duty,
        input  o_ready
    );
    modport slave (
        input  i_valid, i_freq, i_dur_ms, i_duty,
        output o_ready
    );
`else
    modport master (
        output i_valid, i_freq, i_dur_ms,
        input  o_ready
    );
    modport slave (
        input  i_valid, i_freq, i_dur_ms,
        output o_ready
    );
`endif
endinterface

// File: rtl/audio_voice.sv
// audio_voice: note-at-a-time square-wave voice (IDLE/CALC/PLAY).
// Optional duty control: define AUDIO_VOICE_DUTY_EN.
module audio_voice #(
    parameter int CLK_FREQ = 12000000,
    parameter int FREQ_W   = 24,
    parameter int DUR_W    = 16,
    parameter int DIV_W    = 24
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    audio_voice_if.slave  note,
    input  logic          i_stop,
    output logic          o_pulse,
    output logic          o_busy,
    output logic          o_done
);
    localparam int MS_CYC = CLK_FREQ / 1000;
    localparam int PRE_W  = $clog2(MS_CYC + 1);
    localparam int CNT_W  = $clog2(DIV_W);
    localparam int P_W    = DIV_W + 1;

    // CLK/(2f) == (CLK/2)/f, so the dividend always fits DIV_W bits
    localparam logic [DIV_W-1:0] HALF     = DIV_W'(CLK_FREQ / 2);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        PLAY
    } state_e;

    state_e            state_q, state_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [FREQ_W-1:0] rem_q, rem_d;
    logic [DIV_W-1:0]  quo_q, quo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [P_W-1:0]    last_q, last_d;
    logic [P_W-1:0]    thr_q, thr_d;
    logic [P_W-1:0]    p_q, p_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              pulse_q, pulse_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
`ifdef AUDIO_VOICE_DUTY_EN
    logic [7:0]        duty_q, duty_d;
    logic [P_W+7:0]    prod;
`endif

    logic [FREQ_W:0]   trial;
    logic [FREQ_W:0]   diff;
    logic              q_bit;
    logic [DIV_W-1:0]  quo_fin;
    logic [DIV_W-1:0]  h_val;
    logic [P_W-1:0]    two_h;
    logic [P_W-1:0]    thr_val;
    logic [P_W-1:0]    p_nxt;

    // One restoring-divide step plus the half-period/threshold it yields
    always_comb begin
        trial   = {rem_q, HALF[cnt_q]};
        diff    = trial - {1'b0, freq_q};
        q_bit   = (trial >= {1'b0, freq_q});
        quo_fin = {quo_q[DIV_W-2:0], q_bit};
        h_val   = (quo_fin == '0) ? DIV_W'(1) : quo_fin;
        two_h   = {h_val, 1'b0};
`ifdef AUDIO_VOICE_DUTY_EN
        prod    = (P_W+8)'(two_h) * (P_W+8)'(duty_q);
        thr_val = prod[P_W+7:8];
`else
        thr_val = {1'b0, h_val};
`endif
        p_nxt   = (p_q == last_q) ? '0 : p_q + P_W'(1);
    end

    // Next-state and datapath updates for the note engine
    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        dur_d   = dur_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        thr_d   = thr_q;
        p_d     = p_q;
        pre_d   = pre_q;
        pulse_d = pulse_q;
        done_d  = 1'b0;
`ifdef AUDIO_VOICE_DUTY_EN
        duty_d  = duty_q;
`endif
        unique case (state_q)
            IDLE: begin
                pulse_d = 1'b0;
                if (note.i_valid && ready_q && !i_stop) begin
                    freq_d = note.i_freq;
                    dur_d  = note.i_dur_ms;
`ifdef AUDIO_VOICE_DUTY_EN
                    duty_d = note.i_duty;
`endif
                    if (note.i_dur_ms == '0) begin
                        done_d = 1'b1;
                    end else if (note.i_freq == '0) begin
                        // rest: zero threshold keeps the pin low
                        state_d = PLAY;
                        last_d  = P_W'(1);
                        thr_d   = '0;
                        p_d     = '0;
                        pre_d   = '0;
                    end else begin
                        state_d = CALC;
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = CNT_LAST;
                    end
                end
            end
            CALC: begin
                rem_d = q_bit ? diff[FREQ_W-1:0] : trial[FREQ_W-1:0];
                quo_d = quo_fin;
                cnt_d = cnt_q - CNT_W'(1);
                if (i_stop) begin
                    state_d = IDLE;
                    pulse_d = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = PLAY;
                    last_d  = two_h - P_W'(1);
                    thr_d   = thr_val;
                    p_d     = '0;
                    pre_d   = '0;
                    pulse_d = (thr_val != '0);
                end
            end
            PLAY: begin
                if (i_stop) begin
                    state_d = IDLE;
                    pulse_d = 1'b0;
                end else begin
                    p_d     = p_nxt;
                    pulse_d = (p_nxt < thr_q);
                    if (pre_q == PRE_LAST) begin
                        pre_d = '0;
                        if (dur_q == DUR_W'(1)) begin
                            state_d = IDLE;
                            pulse_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            dur_d = dur_q - DUR_W'(1);
                        end
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pulse_d = 1'b0;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            freq_q  <= '0;
            dur_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            thr_q   <= '0;
            p_q     <= '0;
            pre_q   <= '0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef AUDIO_VOICE_DUTY_EN
            duty_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            dur_q   <= dur_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            thr_q   <= thr_d;
            p_q     <= p_d;
            pre_q   <= pre_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
            ready_q <= ready_d;
`ifdef AUDIO_VOICE_DUTY_EN
            duty_q  <= duty_d;
`endif
        end
    end

    assign note.o_ready = ready_q;
    assign o_pulse      = pulse_q;
    assign o_done       = done_q;
    assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_audio_voice.sv
// tb_audio_voice: scoreboard bench for audio_voice.
// Each note's expected shape comes from plain arithmetic on f/dur/duty.
module tb_audio_voice;
    localparam int CLK_FREQ = 12000000;
    localparam int FREQ_W   = 24;
    localparam int DUR_W    = 16;
    localparam int DIV_W    = 24;
    localparam int MS       = CLK_FREQ / 1000;
`ifdef AUDIO_VOICE_DUTY_EN
    localparam bit DUTY_EN = 1'b1;
`else
    localparam bit DUTY_EN = 1'b0;
`endif

    typedef struct {
        int acc;
        int busy;
        int high;
        int run;
        int lead;
        bit done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stop = 1'b0;
    logic pulse, busy, done;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    audio_voice_if #(.FREQ_W(FREQ_W), .DUR_W(DUR_W)) note();

    audio_voice #(
        .CLK_FREQ(CLK_FREQ),
        .FREQ_W(FREQ_W),
        .DUR_W(DUR_W),
        .DIV_W(DIV_W)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .note(note),
        .i_stop(stop),
        .o_pulse(pulse),
        .o_busy(busy),
        .o_done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Expected observation of one note, from frequency/duration arithmetic
    function automatic exp_t model(input int acc, input int f, input int d,
                                   input int duty, input int cut);
        exp_t   e;
        longint h, t, l, r;
        int     calc;
        e.acc = acc;
        if (d == 0) begin
            e.busy = 0; e.high = 0; e.run = 0; e.lead = 0; e.done = 1'b1;
            return e;
        end
        calc = (f == 0) ? 0 : DIV_W;
        l = (cut > 0) ? longint'(cut) : longint'(d) * MS;
        h = 1;
        t = 0;
        if (f != 0) begin
            h = longint'(CLK_FREQ) / (2 * longint'(f));
            if (h == 0) h = 1;
            t = DUTY_EN ? (2 * h * duty) / 256 : h;
        end
        r = l % (2 * h);
        e.busy = calc + int'(l);
        e.high = int'((l / (2 * h)) * t + ((r < t) ? r : t));
        e.run  = (t == 0) ? 0 : int'((t < l) ? t : l);
        e.lead = (t == 0) ? e.busy : calc;
        e.done = (cut == 0);
        return e;
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(note.o_ready && !busy) && n < 40000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy after %0d cycles required idle", n);
        end
    endtask

    // Issue one note; cut>0 aborts it after cut PLAY cycles by stop or reset
    task automatic send(input int f, input int d, input int duty,
                        input int cut, input bit by_rst);
        int acc, calc, target;
        wait_idle();
        note.i_valid  = 1'b1;
        note.i_freq   = FREQ_W'(f);
        note.i_dur_ms = DUR_W'(d);
`ifdef AUDIO_VOICE_DUTY_EN
        note.i_duty   = 8'(duty);
`endif
        acc = cyc + 1;
        sb.push_back(model(acc, f, d, duty, cut));
        @(posedge clk);
        #1;
        note.i_valid = 1'b0;
        note.i_freq  = FREQ_W'($urandom);
        if (cut > 0) begin
            calc = (f == 0) ? 0 : DIV_W;
            target = acc + calc + cut - 1;
            do @(negedge clk); while (cyc < target);
            if (!by_rst) begin
                stop = 1'b1;
                @(posedge clk);
                #1;
                stop = 1'b0;
            end else begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("rst_pulse", pulse, 0);
                chk("rst_ready", note.o_ready, 1);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
    endtask

    // Monitor: measure every note the DUT plays and compare on its end
    initial begin : monitor
        int   bc = 0, hc = 0, rc = 0, lc = 0;
        bit   seen = 1'b0, rdone = 1'b0, prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            chk("ready_vs_busy", note.o_ready, !busy);
            if (!busy) chk("pulse_idle", pulse, 0);
            if (busy) begin
                bc++;
                if (pulse) begin
                    hc++;
                    seen = 1'b1;
                    if (!rdone) rc++;
                end else begin
                    if (seen) rdone = 1'b1;
                    else lc++;
                end
            end
            if ((prev && !busy) || (!prev && !busy && done)) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_note: got note end at cycle %0d required none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_flag", done, e.done);
                    chk("busy_cycles", bc, e.busy);
                    chk("high_cycles", hc, e.high);
                    chk("first_run", rc, e.run);
                    chk("lead_low", lc, e.lead);
                    chk("end_cycle", cyc, e.acc + e.busy);
                end
                bc = 0; hc = 0; rc = 0; lc = 0;
                seen = 1'b0;
                rdone = 1'b0;
            end
            prev = busy;
        end
    end

    initial begin : driver
        int f;
        note.i_valid  = 1'b0;
        note.i_freq   = '0;
        note.i_dur_ms = '0;
`ifdef AUDIO_VOICE_DUTY_EN
        note.i_duty   = 8'd128;
`endif
        repeat (3) @(negedge clk);
        chk("reset_pulse", pulse, 0);
        chk("reset_ready", note.o_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst_n = 1'b1;

        send(1000, 2, 128, 0, 1'b0);
        send(0, 1, 128, 0, 1'b0);
        send(440, 0, 128, 0, 1'b0);
        send(1000, 5, 128, 3000, 1'b0);

        wait_idle();
        note.i_valid  = 1'b1;
        note.i_freq   = FREQ_W'(500);
        note.i_dur_ms = DUR_W'(1);
        stop = 1'b1;
        @(posedge clk);
        #1;
        note.i_valid = 1'b0;
        stop = 1'b0;
        chk("stop_valid_busy", busy, 0);
        chk("stop_valid_ready", note.o_ready, 1);

        send(8000000, 1, 128, 0, 1'b0);
        send(5000, 1, 128, 1000, 1'b1);

        f = $urandom_range(20000, 200);
        send(f, 1, 64, 0, 1'b0);
        f = $urandom_range(199, 20);
        send(f, 1, 0, 0, 1'b0);

        wait_idle();
        repeat (2) @(negedge clk);
        chk("scoreboard_left", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
